seq_detector_multi: RTL and testbench
=====================================

Name: seq_detector_multi

Overview:
Parametrised Mealy serial-pattern detector. It watches a 1-bit input stream for up to NUM_PAT programmable patterns of PAT_LEN bits each, in overlapping or non-overlapping mode. Match outputs are combinational from the current input bit and the registered history, and each pattern has a saturating match counter. It generalises the fixed 2-pattern, 3-bit detector and keeps that block's default configuration (101 and 110, overlapping) as its reset state.

Parameters:
PAT_LEN, 3, pattern length in bits; must be >= 2.
NUM_PAT, 2, number of patterns detected in parallel; must be >= 1.
CNT_W, 8, width of each per-pattern saturating match counter.
RESET_PAT, {3'b110, 3'b101}, pattern register reset value, NUM_PAT*PAT_LEN bits; pattern k occupies bits [k*PAT_LEN +: PAT_LEN].
ID_W, max(1, clog2(NUM_PAT)), width of the match index output.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_valid  in  1  i_a carries a stream bit this cycle.
i_a  in  1  serial input bit.
i_overlap  in  1  1 = overlapping detection; 0 = history flushed after any match.
i_load  in  1  load i_pattern into the pattern register and flush history.
i_pattern  in  NUM_PAT*PAT_LEN  new patterns; in each pattern the MSB is the oldest bit.
i_clear  in  1  synchronous clear of history and all counters.
o_match  out  NUM_PAT  per-pattern match strobe (Mealy, combinational).
o_any  out  1  OR of o_match.
o_match_id  out  ID_W  index of the lowest-numbered matching pattern; 0 when o_any=0.
o_count  out  NUM_PAT*CNT_W  per-pattern match counts; pattern k at [k*CNT_W +: CNT_W].

Behaviour:
- State: pat_r (NUM_PAT*PAT_LEN), hist (PAT_LEN-1 bits, MSB oldest), fill (0..PAT_LEN-1), and NUM_PAT counters.
- Reset (i_reset_n=0, async): pat_r=RESET_PAT, hist=0, fill=0, counters=0. As a result, o_match=0, o_any=0, o_match_id=0, o_count=0.
- Window = {hist, i_a}. o_match[k] = i_valid & ~i_load & ~i_clear & (fill==PAT_LEN-1) & (window==pat_r[k]).
- Latency: a match is flagged in the same cycle as the pattern's last bit. There is no registered output stage.
- Priority per edge is i_load > i_clear > i_valid.
- i_load: pat_r<=i_pattern, hist<=0, fill<=0. Counters are kept. i_a is discarded that cycle.
- i_clear: hist<=0, fill<=0, all counters<=0. pat_r is kept. i_a is discarded.
- i_valid, no match, or i_overlap=1: hist<={hist[PAT_LEN-3:0], i_a} (for PAT_LEN=2, hist<=i_a); fill<=min(fill+1, PAT_LEN-1).
- i_valid with o_any=1 and i_overlap=0: hist<=0, fill<=0. The next match needs PAT_LEN fresh bits.
- i_valid=0: all state holds and o_match=0.
- Counters: counter k increments on o_match[k] and saturates at 2^CNT_W-1 with no wrap. Several patterns may match in the same cycle; each increments.
- Identical patterns: both o_match bits assert; o_match_id reports the lower index.
- i_overlap may change on any cycle and takes effect on the current cycle's match.
- No illegal states: fill is clamped; any out-of-range value reloads to 0.

Test Plan:
1. Reset defaults, overlap=1, valid stream 1,1,0,1,1,0 -> o_match=10 (110) on bit 3, 01 (101) on bit 4, 10 on bit 6; counts end P0=1, P1=2; o_match_id=1,0,1 on those cycles.
2. Same stream with overlap=0 -> matches only on bits 3 and 6 (both 110); counts P0=0, P1=2.
3. Insert i_valid=0 gaps of 1 to 3 cycles between bits of test 1 -> identical match sequence; o_match=0 during gaps.
4. i_load with patterns {111, 000}, then stream 1,1,1,1,0,0,0 with overlap=1 -> P0 (000) fires on bit 7; P1 (111) fires on bits 3 and 4; bits arriving on the load cycle are ignored.
5. CNT_W=2, stream 1,0,1,0,1,0,1,0,1 (overlap) -> P0 matches 4 times; count saturates at 3 and holds. Then i_clear -> count=0, first post-clear match needs 3 new bits.
6. Assert i_reset_n low mid-stream, asynchronously and between edges -> outputs 0 immediately; pat_r returns to RESET_PAT; after release, detection restarts with fill=0.

Source files
------------

// File: rtl/seq_detector_multi.sv
// seq_detector_multi: programmable multi-pattern Mealy serial detector with per-pattern saturating match counters.
// Reset configuration is 101 / 110 with overlapping detection driven by i_overlap.
module seq_detector_multi #(
    parameter int PAT_LEN = 3,
    parameter int NUM_PAT = 2,
    parameter int CNT_W = 8,
    parameter logic [NUM_PAT*PAT_LEN-1:0] RESET_PAT = {3'b110, 3'b101},
    parameter int ID_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_valid,
    input  logic                       i_a,
    input  logic                       i_overlap,
    input  logic                       i_load,
    input  logic [NUM_PAT*PAT_LEN-1:0] i_pattern,
    input  logic                       i_clear,
    output logic [NUM_PAT-1:0]         o_match,
    output logic                       o_any,
    output logic [ID_W-1:0]            o_match_id,
    output logic [NUM_PAT*CNT_W-1:0]   o_count
);
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

    logic [NUM_PAT*PAT_LEN-1:0] pat_r;
    logic [PAT_LEN-2:0]         hist;
    logic [FW-1:0]              fill;
    logic [CNT_W-1:0]           cnt [NUM_PAT];
    logic [PAT_LEN-1:0]         window;
    logic                       live;

    assign window = {hist, i_a};
    // Load and clear discard the incoming bit, so they also mask any match on it.
    assign live = i_valid & ~i_load & ~i_clear & (fill == FULL);

    for (genvar g = 0; g < NUM_PAT; g++) begin : g_pat
        assign o_match[g] = live & (window == pat_r[g*PAT_LEN +: PAT_LEN]);
        assign o_count[g*CNT_W +: CNT_W] = cnt[g];
    end

    assign o_any = |o_match;

    always_comb begin
        o_match_id = '0;
        for (int k = NUM_PAT - 1; k >= 0; k--)
            if (o_match[k]) o_match_id = ID_W'(k);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pat_r <= RESET_PAT;
            hist  <= '0;
            fill  <= '0;
            for (int k = 0; k < NUM_PAT; k++) cnt[k] <= '0;
        end else if (i_load) begin
            pat_r <= i_pattern;
            hist  <= '0;
            fill  <= '0;
        end else if (i_clear) begin
            hist <= '0;
            fill <= '0;
            for (int k = 0; k < NUM_PAT; k++) cnt[k] <= '0;
        end else if (fill > FULL) begin
            fill <= '0;
        end else if (i_valid) begin
            if (o_any && !i_overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[PAT_LEN-2:0];
                fill <= (fill == FULL) ? FULL : fill + FW'(1);
            end
            for (int k = 0; k < NUM_PAT; k++)
                if (o_match[k] && cnt[k] != '1) cnt[k] <= cnt[k] + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_seq_detector_multi.sv
// tb_seq_detector_multi: directed-vector bench for seq_detector_multi (3-bit patterns, 2 patterns, 2-bit counters).
module tb_seq_detector_multi;
    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_a = 1'b0;
    logic       i_overlap = 1'b1;
    logic       i_load = 1'b0;
    logic       i_clear = 1'b0;
    logic [5:0] i_pattern = '0;
    logic [1:0] o_match;
    logic       o_any;
    logic [0:0] o_match_id;
    logic [3:0] o_count;
    int vecs = 0;
    int errs = 0;

    always #5 i_clk = ~i_clk;

    seq_detector_multi #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(2)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_a(i_a),
        .i_overlap(i_overlap), .i_load(i_load), .i_pattern(i_pattern), .i_clear(i_clear),
        .o_match(o_match), .o_any(o_any), .o_match_id(o_match_id), .o_count(o_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled on the falling edge.
    task automatic step(input string tag, input logic v, input logic a, input logic [1:0] em);
        i_valid = v;
        i_a = a;
        @(negedge i_clk);
        check({tag, ".match"}, 32'(o_match), 32'(em));
        check({tag, ".any"}, 32'(o_any), 32'(|em));
        check({tag, ".id"}, 32'(o_match_id), 32'(em[1] & ~em[0]));
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic clear_step(input string tag);
        i_clear = 1'b1;
        step(tag, 1'b1, 1'b1, 2'b00);
        i_clear = 1'b0;
        check({tag, ".cnt"}, 32'(o_count), 32'h0);
    endtask

    initial begin
        #2;
        check("rst.cnt", 32'(o_count), 32'h0);
        check("rst.match", 32'(o_match), 32'h0);
        check("rst.id", 32'(o_match_id), 32'h0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        // Overlapping, default patterns P0=101, P1=110
        step("t1.b1", 1, 1, 2'b00);
        step("t1.b2", 1, 1, 2'b00);
        step("t1.b3", 1, 0, 2'b10);
        step("t1.b4", 1, 1, 2'b01);
        step("t1.b5", 1, 1, 2'b00);
        step("t1.b6", 1, 0, 2'b10);
        check("t1.cnt", 32'(o_count), 32'h9);
        clear_step("t1.clr");

        // Non-overlapping
        i_overlap = 1'b0;
        step("t2.b1", 1, 1, 2'b00);
        step("t2.b2", 1, 1, 2'b00);
        step("t2.b3", 1, 0, 2'b10);
        step("t2.b4", 1, 1, 2'b00);
        step("t2.b5", 1, 1, 2'b00);
        step("t2.b6", 1, 0, 2'b10);
        check("t2.cnt", 32'(o_count), 32'h8);
        i_overlap = 1'b1;
        clear_step("t2.clr");

        // Valid gaps leave the match sequence unchanged
        step("t3.b1", 1, 1, 2'b00);
        step("t3.g1", 0, 1, 2'b00);
        step("t3.b2", 1, 1, 2'b00);
        step("t3.g2", 0, 0, 2'b00);
        step("t3.g3", 0, 1, 2'b00);
        step("t3.b3", 1, 0, 2'b10);
        step("t3.g4", 0, 1, 2'b00);
        step("t3.g5", 0, 1, 2'b00);
        step("t3.g6", 0, 1, 2'b00);
        step("t3.b4", 1, 1, 2'b01);
        step("t3.g7", 0, 0, 2'b00);
        step("t3.b5", 1, 1, 2'b00);
        step("t3.g8", 0, 1, 2'b00);
        step("t3.g9", 0, 1, 2'b00);
        step("t3.b6", 1, 0, 2'b10);
        check("t3.cnt", 32'(o_count), 32'h9);

        // Load P0=000, P1=111; window 101 on the load cycle must be masked
        i_load = 1'b1;
        i_pattern = {3'b111, 3'b000};
        step("t4.load", 1, 1, 2'b00);
        i_load = 1'b0;
        check("t4.keep", 32'(o_count), 32'h9);
        clear_step("t4.clr");
        step("t4.b1", 1, 1, 2'b00);
        step("t4.b2", 1, 1, 2'b00);
        step("t4.b3", 1, 1, 2'b10);
        step("t4.b4", 1, 1, 2'b10);
        step("t4.b5", 1, 0, 2'b00);
        step("t4.b6", 1, 0, 2'b00);
        step("t4.b7", 1, 0, 2'b01);
        check("t4.cnt", 32'(o_count), 32'h9);

        // Async reset between edges while a match is live
        step("t6.b1", 1, 1, 2'b00);
        step("t6.b2", 1, 1, 2'b00);
        i_valid = 1'b1;
        i_a = 1'b1;
        #1;
        check("t6.pre", 32'(o_match), 32'h2);
        #1;
        i_reset_n = 1'b0;
        #1;
        check("t6.match", 32'(o_match), 32'h0);
        check("t6.any", 32'(o_any), 32'h0);
        check("t6.cnt", 32'(o_count), 32'h0);
        @(posedge i_clk);
        #1;
        check("t6.hold", 32'(o_count), 32'h0);
        i_valid = 1'b0;
        i_reset_n = 1'b1;

        // Restored 101/110 patterns, fresh fill, counter saturation at 3
        step("t5.b1", 1, 1, 2'b00);
        step("t5.b2", 1, 0, 2'b00);
        step("t5.b3", 1, 1, 2'b01);
        step("t5.b4", 1, 0, 2'b00);
        step("t5.b5", 1, 1, 2'b01);
        step("t5.b6", 1, 0, 2'b00);
        step("t5.b7", 1, 1, 2'b01);
        check("t5.sat", 32'(o_count), 32'h3);
        step("t5.b8", 1, 0, 2'b00);
        step("t5.b9", 1, 1, 2'b01);
        check("t5.hold", 32'(o_count), 32'h3);
        clear_step("t5.clr");
        step("t5.c1", 1, 1, 2'b00);
        step("t5.c2", 1, 0, 2'b00);
        step("t5.c3", 1, 1, 2'b01);
        check("t5.cnt", 32'(o_count), 32'h1);

        // Identical patterns: both fire, lowest index reported
        i_load = 1'b1;
        i_pattern = {3'b101, 3'b101};
        step("t7.load", 0, 0, 2'b00);
        i_load = 1'b0;
        step("t7.b1", 1, 1, 2'b00);
        step("t7.b2", 1, 0, 2'b00);
        step("t7.b3", 1, 1, 2'b11);
        check("t7.cnt", 32'(o_count), 32'h6);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
